mem_stage_m2w: RTL and testbench
================================

Name: mem_stage_m2w

Overview:
- Memory stage plus memory-to-writeback pipeline register of the pipelined ARM datapath.
- Consumes the execute-to-memory register outputs (ALUOutM, WriteDataM, WA3M and M-stage control).
- Performs the data-memory access over a ready-handshake bus and raises StallM while the access waits.
- Registers the W-stage values, including ResultW, that feed the register file.

Parameters:
- WAIT_LIMIT, 0, maximum WAIT cycles before an access is aborted; 0 = unlimited.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- RegWriteM  in  1  M-stage instruction writes the register file
- MemtoRegM  in  1  M-stage instruction is a load
- MemWriteM  in  1  M-stage instruction is a store
- ByteM  in  1  byte access (LDRB/STRB); used only with the optional feature
- ALUOutM  in  32  effective address or ALU result
- WriteDataM  in  32  store data
- WA3M  in  4  destination register
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr  out  32  address, always ALUOutM
- mem_wdata  out  32  write data
- mem_be  out  4  byte enables
- mem_rdata  in  32  read data, valid when mem_ready=1
- mem_ready  in  1  access completes this cycle
- StallM  out  1  to hazard unit: freeze F, D, E and the E-to-M register
- RegWriteW  out  1  registered write enable
- MemtoRegW  out  1  registered load flag
- ReadDataW  out  32  registered load data
- ALUOutW  out  32  registered ALU result
- WA3W  out  4  registered destination register
- ResultW  out  32  combinational: MemtoRegW ? ReadDataW : ALUOutW
- BusErrW  out  1  one-cycle pulse: an access was aborted by timeout

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- memop = MemWriteM | MemtoRegM. Writes take priority if both are set.
- FSM has two states: IDLE and WAIT.
- IDLE:
  - mem_req = memop.
  - If memop and mem_ready: zero-wait completion; StallM=0.
  - If memop and not mem_ready: StallM=1; next state WAIT; wait counter loads 1.
  - If no memop: StallM=0 and mem_ready is ignored.
- WAIT:
  - mem_req=1, and mem_addr, mem_we, mem_wdata and mem_be hold stable (M inputs are frozen by the stall).
  - StallM = ~mem_ready.
  - On mem_ready: next state IDLE, counter clears.
  - Otherwise the counter increments.
- Timeout (WAIT_LIMIT>0, counter==WAIT_LIMIT, mem_ready=0):
  - Abort: StallM=0 this cycle, mem_req still 1, next state IDLE.
  - The W register captures the instruction with RegWriteW=0 and MemtoRegW=0; BusErrW=1 next cycle.
  - mem_ready arriving in the same cycle wins: normal completion.
- W register update, every clk edge:
  - StallM=1: bubble. RegWriteW=0, MemtoRegW=0, BusErrW=0; data fields hold.
  - Otherwise: RegWriteW←RegWriteM, MemtoRegW←MemtoRegM, ALUOutW←ALUOutM, WA3W←WA3M.
  - ReadDataW←formatted mem_rdata if load, else 0.
- Word access: mem_be=4'hF, mem_wdata=WriteDataM, load data = mem_rdata unchanged.
- mem_we = MemWriteM whenever mem_req=1, else 0.
- Reset:
  - State IDLE, counter 0.
  - RegWriteW, MemtoRegW, BusErrW = 0; ReadDataW, ALUOutW = 0; WA3W = 0.
  - While reset=1, mem_req=0 and StallM=0, including reset asserted mid-WAIT; the pending access is abandoned.
- Back-to-back memory ops: each completes independently, with no idle cycle required between them.

Optional Feature:
- Macro: MEM_BYTE_ACCESS_EN.
- Defined:
  - ByteM=1 store: mem_wdata={4{WriteDataM[7:0]}}, mem_be=4'b0001<<ALUOutM[1:0].
  - ByteM=1 load: mem_be is the same one-hot lane; ReadDataW = zero-extended byte of mem_rdata selected by ALUOutM[1:0].
- Undefined: ByteM is ignored; all accesses are word accesses. The port list is unchanged.

Test Plan:
- Reset held 2 cycles mid-WAIT -> mem_req=0 and StallM=0 during reset; all W outputs 0 after reset; FSM IDLE.
- Load ALUOutM=0x100, WA3M=5, mem_ready=1 same cycle, mem_rdata=0xDEADBEEF -> StallM never 1; next cycle ReadDataW=0xDEADBEEF, ResultW=0xDEADBEEF, RegWriteW=1, WA3W=5.
- Store ALUOutM=0x200, WriteDataM=0x12345678, mem_ready low 3 cycles -> StallM=1 for 3 cycles; W sees 3 bubbles (RegWriteW=0); mem_we=1, mem_be=F and address stable throughout; completion on cycle 4.
- WAIT_LIMIT=4, load with mem_ready held 0 -> abort at the limit; BusErrW pulses one cycle; RegWriteW=0; FSM IDLE; the next ALU instruction passes normally.
- MEM_BYTE_ACCESS_EN defined: STRB to 0x203 with data 0xAB -> mem_be=4'b1000, mem_wdata=0xABABABAB. LDRB from 0x201 with mem_rdata=0x11223344 -> ReadDataW=0x00000033.
- Non-memory op ALUOutM=0x55, RegWriteM=1, with mem_ready toggling randomly -> mem_req=0, StallM=0, ResultW=0x55 one cycle later.

Source files
------------

// File: rtl/mem_stage_m2w.sv
// Memory stage and M-to-W pipeline register: ready-handshake data access with
// stall/timeout, plus W register. Optional byte lanes via MEM_BYTE_ACCESS_EN.
module mem_stage_m2w #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteM,
  input  logic        MemtoRegM,
  input  logic        MemWriteM,
  input  logic        ByteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [3:0]  WA3M,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        StallM,
  output logic        RegWriteW,
  output logic        MemtoRegW,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic [31:0] ResultW,
  output logic        BusErrW
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        memop, is_load, timeout;
  logic [31:0] rdata_fmt;

  logic        regwrite_w_q, regwrite_w_d;
  logic        memtoreg_w_q, memtoreg_w_d;
  logic        buserr_w_q, buserr_w_d;
  logic [31:0] readdata_w_q, readdata_w_d;
  logic [31:0] aluout_w_q, aluout_w_d;
  logic [3:0]  wa3_w_q, wa3_w_d;

  // A store wins when both memory flags are set.
  assign memop    = MemWriteM | MemtoRegM;
  assign is_load  = MemtoRegM & ~MemWriteM;
  assign mem_addr = ALUOutM;
  assign mem_we   = mem_req & MemWriteM;

`ifdef MEM_BYTE_ACCESS_EN
  always_comb begin
    mem_be    = 4'hF;
    mem_wdata = WriteDataM;
    rdata_fmt = mem_rdata;
    if (ByteM) begin
      mem_be    = 4'b0001 << ALUOutM[1:0];
      mem_wdata = {4{WriteDataM[7:0]}};
      case (ALUOutM[1:0])
        2'd0:    rdata_fmt = {24'h0, mem_rdata[7:0]};
        2'd1:    rdata_fmt = {24'h0, mem_rdata[15:8]};
        2'd2:    rdata_fmt = {24'h0, mem_rdata[23:16]};
        default: rdata_fmt = {24'h0, mem_rdata[31:24]};
      endcase
    end
  end
`else
  logic byte_unused;
  assign byte_unused = ByteM;
  assign mem_be      = 4'hF;
  assign mem_wdata   = WriteDataM;
  assign rdata_fmt   = mem_rdata;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_req = 1'b0;
    StallM  = 1'b0;
    timeout = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          mem_req = memop;
          if (memop && !mem_ready) begin
            StallM  = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 32'd1;
          end
        end
        S_WAIT: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end else if (WAIT_LIMIT != 0 && cnt_q == WAIT_LIMIT) begin
            // Abort: release the pipeline and retire the op as a no-write.
            timeout = 1'b1;
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end else begin
            StallM = 1'b1;
            cnt_d  = cnt_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    regwrite_w_d = 1'b0;
    memtoreg_w_d = 1'b0;
    buserr_w_d   = 1'b0;
    readdata_w_d = readdata_w_q;
    aluout_w_d   = aluout_w_q;
    wa3_w_d      = wa3_w_q;
    if (!StallM) begin
      regwrite_w_d = RegWriteM & ~timeout;
      memtoreg_w_d = MemtoRegM & ~timeout;
      buserr_w_d   = timeout;
      aluout_w_d   = ALUOutM;
      wa3_w_d      = WA3M;
      readdata_w_d = (is_load && !timeout) ? rdata_fmt : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      regwrite_w_q <= 1'b0;
      memtoreg_w_q <= 1'b0;
      buserr_w_q   <= 1'b0;
      readdata_w_q <= 32'h0;
      aluout_w_q   <= 32'h0;
      wa3_w_q      <= 4'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      regwrite_w_q <= regwrite_w_d;
      memtoreg_w_q <= memtoreg_w_d;
      buserr_w_q   <= buserr_w_d;
      readdata_w_q <= readdata_w_d;
      aluout_w_q   <= aluout_w_d;
      wa3_w_q      <= wa3_w_d;
    end
  end

  assign RegWriteW = regwrite_w_q;
  assign MemtoRegW = memtoreg_w_q;
  assign BusErrW   = buserr_w_q;
  assign ReadDataW = readdata_w_q;
  assign ALUOutW   = aluout_w_q;
  assign WA3W      = wa3_w_q;
  assign ResultW   = memtoreg_w_q ? readdata_w_q : aluout_w_q;
endmodule

// File: tb/tb_mem_stage_m2w.sv
// Directed bench for mem_stage_m2w (WAIT_LIMIT=4) with an access-age reference
// model checked every negedge; byte cases run when MEM_BYTE_ACCESS_EN is set.
module tb_mem_stage_m2w;
  localparam int WL = 4;
`ifdef MEM_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0, reset;
  logic        RegWriteM, MemtoRegM, MemWriteM, ByteM;
  logic [31:0] ALUOutM, WriteDataM, mem_rdata;
  logic [3:0]  WA3M;
  logic        mem_ready;
  logic        mem_req, mem_we, StallM, RegWriteW, MemtoRegW, BusErrW;
  logic [31:0] mem_addr, mem_wdata, ReadDataW, ALUOutW, ResultW;
  logic [3:0]  mem_be, WA3W;

  int checks = 0, errors = 0;

  mem_stage_m2w #(.WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemWriteM(MemWriteM), .ByteM(ByteM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .WA3M(WA3M), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallM(StallM), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ReadDataW(ReadDataW),
    .ALUOutW(ALUOutW), .WA3W(WA3W), .ResultW(ResultW), .BusErrW(BusErrW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic b);
    return (BYTE_EN && b) ? (4'd1 << a[1:0]) : 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic b);
    return (BYTE_EN && b) ? (d[7:0] * 32'h01010101) : d;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] r, input logic [31:0] a, input logic b);
    return (BYTE_EN && b) ? ((r >> (8 * a[1:0])) & 32'hFF) : r;
  endfunction

  // Reference model: age = cycles the current access has already waited.
  int          age = 0;
  bit          w_known = 0;
  logic        m_rw, m_mr, m_be;
  logic [31:0] m_rd, m_alu;
  logic [3:0]  m_wa;

  always @(negedge clk) begin
    logic memop, e_req, e_stall, abort, ld;
    memop = MemWriteM | MemtoRegM;
    ld    = MemtoRegM & ~MemWriteM;
    abort = 1'b0;
    if (reset) begin
      e_req = 1'b0; e_stall = 1'b0;
    end else begin
      e_req   = memop;
      abort   = memop && !mem_ready && WL > 0 && age == WL;
      e_stall = memop && !mem_ready && !abort;
    end
    chk("m_req", mem_req, e_req);
    chk("m_stall", StallM, e_stall);
    chk("m_we", mem_we, e_req & MemWriteM);
    if (e_req) begin
      chk("m_addr", mem_addr, ALUOutM);
      chk("m_be", mem_be, exp_be(ALUOutM, ByteM));
      if (MemWriteM) chk("m_wdata", mem_wdata, exp_wd(WriteDataM, ByteM));
    end
    if (w_known) begin
      chk("m_RegWriteW", RegWriteW, m_rw);
      chk("m_MemtoRegW", MemtoRegW, m_mr);
      chk("m_BusErrW", BusErrW, m_be);
      chk("m_ReadDataW", ReadDataW, m_rd);
      chk("m_ALUOutW", ALUOutW, m_alu);
      chk("m_WA3W", WA3W, m_wa);
      chk("m_ResultW", ResultW, m_mr ? m_rd : m_alu);
    end
    if (reset) begin
      age = 0; w_known = 1;
      m_rw = 0; m_mr = 0; m_be = 0; m_rd = 0; m_alu = 0; m_wa = 0;
    end else if (e_stall) begin
      age++;
      m_rw = 0; m_mr = 0; m_be = 0;
    end else begin
      age   = 0;
      m_rw  = RegWriteM & ~abort;
      m_mr  = MemtoRegM & ~abort;
      m_be  = abort;
      m_alu = ALUOutM;
      m_wa  = WA3M;
      m_rd  = (ld && !abort) ? exp_rd(mem_rdata, ALUOutM, ByteM) : 32'h0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input logic rw, mr, mw, bt, input logic [31:0] alu, wd,
                        input logic [3:0] wa, input logic rdy, input logic [31:0] rd);
    RegWriteM = rw; MemtoRegM = mr; MemWriteM = mw; ByteM = bt;
    ALUOutM = alu; WriteDataM = wd; WA3M = wa; mem_ready = rdy; mem_rdata = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    // Store stuck in WAIT, then reset lands on top of it.
    reset = 1'b0;
    set_in(0, 0, 1, 0, 32'h300, 32'hAAAA5555, 0, 0, 0);
    step(); step();
    reset = 1'b1; #1;
    chk("rst_req", mem_req, 0); chk("rst_stall", StallM, 0);
    step();
    chk("rst_req2", mem_req, 0); chk("rst_stall2", StallM, 0);
    step();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rst_RegWriteW", RegWriteW, 0); chk("rst_ReadDataW", ReadDataW, 0);
    chk("rst_ALUOutW", ALUOutW, 0); chk("rst_WA3W", WA3W, 0);
    chk("rst_BusErrW", BusErrW, 0); chk("rst_stall3", StallM, 0);
    step();

    // Zero-wait load.
    set_in(1, 1, 0, 0, 32'h100, 0, 4'd5, 1, 32'hDEADBEEF); #1;
    chk("ld_stall", StallM, 0); chk("ld_req", mem_req, 1);
    step();
    chk("ld_ReadDataW", ReadDataW, 32'hDEADBEEF); chk("ld_ResultW", ResultW, 32'hDEADBEEF);
    chk("ld_RegWriteW", RegWriteW, 1); chk("ld_WA3W", WA3W, 5);

    // Store with three wait cycles.
    set_in(0, 0, 1, 0, 32'h200, 32'h12345678, 4'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("st_stall", StallM, 1); chk("st_we", mem_we, 1);
      chk("st_be", mem_be, 4'hF); chk("st_addr", mem_addr, 32'h200);
      chk("st_wdata", mem_wdata, 32'h12345678);
      step();
      chk("st_bubble", RegWriteW, 0);
    end
    mem_ready = 1'b1; #1;
    chk("st_done_stall", StallM, 0);
    step();
    chk("st_ALUOutW", ALUOutW, 32'h200); chk("st_MemtoRegW", MemtoRegW, 0);

    // Load that never completes: aborted after WL waits.
    set_in(1, 1, 0, 0, 32'h400, 0, 4'd7, 0, 32'h99999999);
    for (int i = 0; i < WL; i++) begin
      #1; chk("to_stall", StallM, 1); step();
    end
    #1;
    chk("to_abort_stall", StallM, 0); chk("to_abort_req", mem_req, 1);
    step();
    chk("to_BusErrW", BusErrW, 1); chk("to_RegWriteW", RegWriteW, 0);
    chk("to_MemtoRegW", MemtoRegW, 0);
    set_in(1, 0, 0, 0, 32'h77, 0, 4'd3, 0, 0);
    step();
    chk("to_next_BusErrW", BusErrW, 0); chk("to_next_ResultW", ResultW, 32'h77);
    chk("to_next_RegWriteW", RegWriteW, 1);

    // ALU op ignores a noisy mem_ready.
    set_in(1, 0, 0, 0, 32'h55, 0, 4'd2, 0, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom); #1;
      chk("alu_req", mem_req, 0); chk("alu_stall", StallM, 0);
      step();
      chk("alu_ResultW", ResultW, 32'h55);
    end

    // Back-to-back memory ops, no idle in between.
    set_in(1, 1, 0, 0, 32'h10, 0, 4'd1, 1, 32'hCAFE0001); step();
    chk("b2b_ld1", ResultW, 32'hCAFE0001);
    set_in(0, 0, 1, 0, 32'h14, 32'h0000BEEF, 4'd0, 1, 0); step();
    chk("b2b_st_rw", RegWriteW, 0);
    set_in(1, 1, 0, 0, 32'h18, 0, 4'd4, 1, 32'h0BADF00D); step();
    chk("b2b_ld2", ResultW, 32'h0BADF00D); chk("b2b_wa", WA3W, 4);

`ifdef MEM_BYTE_ACCESS_EN
    set_in(0, 0, 1, 1, 32'h203, 32'h000000AB, 4'd0, 1, 0); #1;
    chk("strb_be", mem_be, 4'b1000); chk("strb_wdata", mem_wdata, 32'hABABABAB);
    step();
    set_in(1, 1, 0, 1, 32'h201, 0, 4'd6, 1, 32'h11223344); #1;
    chk("ldrb_be", mem_be, 4'b0010);
    step();
    chk("ldrb_ReadDataW", ReadDataW, 32'h00000033); chk("ldrb_ResultW", ResultW, 32'h33);
`endif

    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
